irq_ctrl: RTL
=============

// Module: irq_ctrl
// PURPOSE
//  Interrupt controller directly upstream of the CP0 block. Collects NUM_SRC external sources,
//  detects edges or levels, holds pending bits and applies a mask. Picks the highest-priority
//  request and drives a single request line (ir_out) into CP0's external interrupt input.
//  Holds that request until CP0 takes it, then blocks further requests until ERET.
// PARAMETERS
//  NUM_SRC   8   number of interrupt sources, 1..32
//  ID_W      5   width of irq_id; must be >= clog2(NUM_SRC)
// PORTS
//  clk       in   1        main clock, all logic on rising edge
//  rst_n     in   1        asynchronous, active-low reset
//  irq_src   in   NUM_SRC  raw external interrupt lines, asynchronous to clk
//  wr_en     in   1        register write strobe (MTC0-style, EXE stage)
//  wr_addr   in   5        register write address
//  wr_data   in   32       register write data
//  rd_addr   in   5        register read address
//  rd_data   out  32       register read data, combinational from rd_addr
//  ack       in   1        CP0 has taken the interrupt (its forced jump due to interrupt)
//  eret      in   1        ERET executed in CP0
//  ir_out    out  1        interrupt request to CP0 external interrupt input
//  irq_id    out  ID_W     index of the request presented / in service
// BEHAVIOUR
//  Registers (rd_data is 0 for unmapped addresses):
//   0 IMR    R/W  mask, 1 = enabled, reset 0
//   1 IPR    R/W1C  pending bits, reset 0
//   2 ITYPE  R/W  1 = edge source, 0 = level source, reset all-ones
//   3 ICAUSE RO   {valid, 26'b0, irq_id}, valid=1 in REQ or SERVICE
//  Bits >= NUM_SRC read 0 and ignore writes.
//  Edge source: a rising edge of the synced input sets IPR[i]. A W1C write or ack of that id clears it.
//   - Set and clear in the same cycle: set wins.
//  Level source: IPR[i] = synced level every cycle. W1C and ack have no effect on it.
//  req_vec = IPR & IMR. Priority: lowest index wins (fixed).
//  FSM states:
//   - IDLE:    ir_out=0. If req_vec != 0, latch winner into irq_id and go to REQ.
//   - REQ:     ir_out=1, irq_id held stable.
//              ack -> SERVICE; if the source is edge type, clear IPR[irq_id].
//              If req_vec[irq_id] drops before ack (mask write or level release): withdraw, go to IDLE.
//   - SERVICE: ir_out=0, irq_id held. eret -> IDLE. ack is ignored.
//  Latency: edge at pin -> ir_out high = 2 sync + 1 edge/pending + 1 FSM = 4 clk (with IRQ_SYNC_EN).
//   Without IRQ_SYNC_EN: 2 clk.
//  IDLE->REQ occurs on the cycle after eret at the earliest; there is no same-cycle re-request.
//  ack and eret together in REQ: ack is taken, go to SERVICE. eret is not consumed.
//  rst_n low at any time, including mid-REQ or mid-SERVICE: immediately IDLE.
//   - ir_out=0, irq_id=0, rd_data reflects reset registers, IMR=0, IPR=0, ITYPE=all-ones.
//   - Synchronizer and edge-history flops cleared to 0.
// CONFIGURATION
//  IRQ_SYNC_EN defined: each irq_src bit passes through a 2-flop synchronizer before edge/level logic.
//  IRQ_SYNC_EN undefined: irq_src is sampled directly by one register. Sources must then be
//   synchronous to clk. Latency drops by 2 clk.
// STRUCTURE
//  irq_define.vh: register addresses (IRQ_REG_IMR/IPR/ITYPE/ICAUSE), FSM state encodings
//   (IRQ_S_IDLE/REQ/SERVICE, 2 bits).
//  Sub-module irq_sync: per-bit synchronizer (when IRQ_SYNC_EN) and rising-edge detector.
//   Instantiated once with width NUM_SRC. Outputs lvl[] and rise[].
//  irq_ctrl holds the registers, priority encoder, FSM and read mux.
// TESTING
//  1. Reset, IMR=0xFF, ITYPE=0xFF, pulse irq_src[3] for 1 clk -> ir_out=1 four clks later,
//     irq_id=3, ICAUSE=0x80000003.
//  2. Edge pulses on src 5 and 2 in the same cycle -> irq_id=2. ack -> IPR=0x20, ir_out=0.
//     eret -> ir_out=1 one clk later with irq_id=5.
//  3. In SERVICE, pulse src 1 -> IPR[1]=1 but ir_out stays 0 until eret, then irq_id=1.
//  4. ITYPE=0, hold src 4 high -> REQ with id 4. Drop src 4 before ack -> back to IDLE,
//     ir_out=0, IPR=0.
//  5. IPR[6] pending, W1C write 0x40 coinciding with a new edge on src 6 -> IPR[6] stays 1.
//  6. Assert rst_n=0 while in REQ with irq_id=7 -> ir_out=0, irq_id=0, IMR=0 and IPR=0 at once,
//     without waiting for clk.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register map and FSM state encoding.
// Build option IRQ_SYNC_EN (see irq_sync) does not change anything defined here.
package irq_ctrl_pkg;

    localparam logic [4:0] IRQ_REG_IMR    = 5'd0;
    localparam logic [4:0] IRQ_REG_IPR    = 5'd1;
    localparam logic [4:0] IRQ_REG_ITYPE  = 5'd2;
    localparam logic [4:0] IRQ_REG_ICAUSE = 5'd3;

    typedef enum logic [1:0] {
        IRQ_S_IDLE    = 2'd0,
        IRQ_S_REQ     = 2'd1,
        IRQ_S_SERVICE = 2'd2
    } irq_state_t;

endpackage

// File: rtl/irq_sync.sv
// Per-source input conditioning: optional 2-flop synchronizer (IRQ_SYNC_EN) plus rising-edge detect.
// Latency: lvl is 2 clk behind the pin with IRQ_SYNC_EN, combinational from the pin without it.
module irq_sync #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_src,
    output logic [W-1:0] o_lvl,
    output logic [W-1:0] o_rise
);

    logic [W-1:0] w_lvl;
    logic [W-1:0] r_prev;

`ifdef IRQ_SYNC_EN
    logic [W-1:0] r_s1;
    logic [W-1:0] r_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= i_src;
            r_s2 <= r_s1;
        end
    end

    assign w_lvl = r_s2;
`else
    // Sources are synchronous here; the history flop is the only sampling register.
    assign w_lvl = i_src;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= '0;
        end else begin
            r_prev <= w_lvl;
        end
    end

    assign o_lvl  = w_lvl;
    assign o_rise = w_lvl & ~r_prev;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller feeding CP0: pending/mask registers, fixed lowest-index priority, REQ/SERVICE FSM.
// Input synchronization is selected by IRQ_SYNC_EN (pin to ir_out 4 clk when defined, 2 clk otherwise).
module irq_ctrl #(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               wr_en,
    input  logic [4:0]         wr_addr,
    input  logic [31:0]        wr_data,
    input  logic [4:0]         rd_addr,
    output logic [31:0]        rd_data,
    input  logic               ack,
    input  logic               eret,
    output logic               ir_out,
    output logic [ID_W-1:0]    irq_id
);
    import irq_ctrl_pkg::*;

    logic [NUM_SRC-1:0] w_lvl;
    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] r_imr;
    logic [NUM_SRC-1:0] r_ipr;
    logic [NUM_SRC-1:0] r_itype;
    logic [NUM_SRC-1:0] w_req_vec;
    logic [NUM_SRC-1:0] w_cur_sel;
    logic [NUM_SRC-1:0] w_clr;
    logic [NUM_SRC-1:0] w_ipr_nxt;
    logic [ID_W-1:0]    w_win_id;
    logic               w_cur_req;
    logic               w_ack_take;
    logic               w_wr_imr;
    logic               w_wr_ipr;
    logic               w_wr_itype;
    logic [31:0]        w_rd;
    logic               w_unused;

    irq_state_t         r_state;
    logic               r_ir_out;
    logic [ID_W-1:0]    r_irq_id;

    irq_sync #(
        .W (NUM_SRC)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_src  (irq_src),
        .o_lvl  (w_lvl),
        .o_rise (w_rise)
    );

    assign w_wr_imr   = wr_en && (wr_addr == IRQ_REG_IMR);
    assign w_wr_ipr   = wr_en && (wr_addr == IRQ_REG_IPR);
    assign w_wr_itype = wr_en && (wr_addr == IRQ_REG_ITYPE);
    assign w_unused   = ^wr_data;

    assign w_req_vec  = r_ipr & r_imr;
    assign w_ack_take = (r_state == IRQ_S_REQ) && ack;

    always_comb begin
        w_win_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_req_vec[i]) begin
                w_win_id = ID_W'(i);
            end
        end
    end

    always_comb begin
        w_cur_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_cur_sel[i] = (r_irq_id == ID_W'(i));
        end
    end

    assign w_cur_req = |(w_req_vec & w_cur_sel);

    // Edge bits: a new rise beats any clear in the same cycle. Level bits just track the input.
    assign w_clr     = (w_wr_ipr   ? wr_data[NUM_SRC-1:0] : '0)
                     | (w_ack_take ? w_cur_sel            : '0);
    assign w_ipr_nxt = (r_itype & (w_rise | (r_ipr & ~w_clr)))
                     | (~r_itype & w_lvl);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_imr   <= '0;
            r_ipr   <= '0;
            r_itype <= '1;
        end else begin
            r_ipr <= w_ipr_nxt;
            if (w_wr_imr) begin
                r_imr <= wr_data[NUM_SRC-1:0];
            end
            if (w_wr_itype) begin
                r_itype <= wr_data[NUM_SRC-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IRQ_S_IDLE;
            r_ir_out <= 1'b0;
            r_irq_id <= '0;
        end else begin
            case (r_state)
                IRQ_S_IDLE: begin
                    if (|w_req_vec) begin
                        r_state  <= IRQ_S_REQ;
                        r_ir_out <= 1'b1;
                        r_irq_id <= w_win_id;
                    end
                end
                IRQ_S_REQ: begin
                    if (ack) begin
                        r_state  <= IRQ_S_SERVICE;
                        r_ir_out <= 1'b0;
                    end else if (!w_cur_req) begin
                        r_state  <= IRQ_S_IDLE;
                        r_ir_out <= 1'b0;
                    end
                end
                IRQ_S_SERVICE: begin
                    if (eret) begin
                        r_state <= IRQ_S_IDLE;
                    end
                end
                default: begin
                    r_state  <= IRQ_S_IDLE;
                    r_ir_out <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_rd = '0;
        case (rd_addr)
            IRQ_REG_IMR:    w_rd = 32'(r_imr);
            IRQ_REG_IPR:    w_rd = 32'(r_ipr);
            IRQ_REG_ITYPE:  w_rd = 32'(r_itype);
            IRQ_REG_ICAUSE: begin
                w_rd     = 32'(r_irq_id);
                w_rd[31] = (r_state == IRQ_S_REQ) || (r_state == IRQ_S_SERVICE);
            end
            default:        w_rd = '0;
        endcase
    end

    assign rd_data = w_rd;
    assign ir_out  = r_ir_out;
    assign irq_id  = r_irq_id;

endmodule
